// File: rtl/uart_cmd_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_rx_pkg
//  Purpose  : Shared definitions (cmd_rx_defs) for the framed UART command
//             receiver: default sync marker, command opcodes, expected payload
//             length per opcode, error codes and FSM state encodings.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_cmd_rx_pkg;

    localparam logic [7:0] c_SYNC_BYTE      = 8'hA5;

    localparam logic [7:0] c_CMD_SET_KEY    = 8'h01;
    localparam logic [7:0] c_CMD_SET_PT     = 8'h02;
    localparam logic [7:0] c_CMD_SET_DELAY  = 8'h03;
    localparam logic [7:0] c_CMD_START      = 8'h04;

    localparam logic [7:0] c_LEN_SET_KEY    = 8'd16;
    localparam logic [7:0] c_LEN_SET_PT     = 8'd16;
    localparam logic [7:0] c_LEN_SET_DELAY  = 8'd1;
    localparam logic [7:0] c_LEN_START      = 8'd0;

    localparam logic [1:0] c_ERR_CHKSUM     = 2'b00;
    localparam logic [1:0] c_ERR_BADCMD     = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT    = 2'b10;
    localparam logic [1:0] c_ERR_BUSY       = 2'b11;

    localparam logic [2:0] c_ST_IDLE        = 3'd0;
    localparam logic [2:0] c_ST_CMD         = 3'd1;
    localparam logic [2:0] c_ST_LEN         = 3'd2;
    localparam logic [2:0] c_ST_PAYLOAD     = 3'd3;
    localparam logic [2:0] c_ST_CHK         = 3'd4;

    // True when the opcode is known and LEN matches its fixed payload size.
    function automatic logic f_len_ok(input logic [7:0] cmd, input logic [7:0] len);
        logic w_ok;
        w_ok = 1'b0;
        case (cmd)
            c_CMD_SET_KEY:   w_ok = (len == c_LEN_SET_KEY);
            c_CMD_SET_PT:    w_ok = (len == c_LEN_SET_PT);
            c_CMD_SET_DELAY: w_ok = (len == c_LEN_SET_DELAY);
            c_CMD_START:     w_ok = (len == c_LEN_START);
            default:         w_ok = 1'b0;
        endcase
        return w_ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_rx
//  Purpose  : Framed PC->FPGA command parser on the uart_rx byte stream.
//             Frame = SYNC, CMD, LEN, LEN payload bytes, CHK (XOR of CMD, LEN
//             and payload). Validated frames commit key / plaintext / TDC
//             delay registers or issue a start pulse; bad frames pulse err_o.
//  Ports    : clk, rst (sync, active high)
//             rx_dv, rx_byte          byte strobe + data from uart_rx
//             busy_i                  main FSM busy (blocks START only)
//             key_o/key_vld, pt_o/pt_vld, delay_o/delay_vld, start_o
//             err_o, err_code         reject pulse + held reason
//             ack_valid, ack_byte, ack_ready   only with CMD_ACK_EN defined
//  Config   : CMD_ACK_EN - adds a one-deep acknowledge byte for a uart_tx feeder
//  Revision : 1.0  initial release
// ============================================================================
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = c_SYNC_BYTE,
    parameter int unsigned MAX_DELAY      = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_dv,
    input  logic [7:0]   rx_byte,
    input  logic         busy_i,
    output logic [127:0] key_o,
    output logic         key_vld,
    output logic [127:0] pt_o,
    output logic         pt_vld,
    output logic [4:0]   delay_o,
    output logic         delay_vld,
    output logic         start_o,
    output logic         err_o,
    output logic [1:0]   err_code
`ifdef CMD_ACK_EN
    ,
    output logic         ack_valid,
    output logic [7:0]   ack_byte,
    input  logic         ack_ready
`endif
);

    localparam int unsigned c_TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TLIM = c_TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]      r_state;
    logic [7:0]      r_cmd;
    logic [7:0]      r_chk;
    logic [4:0]      r_rem;
    logic [127:0]    r_stage;
    logic [c_TW-1:0] r_tcnt;

    logic [2:0]      w_state_nx;
    logic            w_timeout;
    logic            w_err;
    logic [1:0]      w_err_code;
    logic            w_ok;

    // Next state and the frame verdict. Errors and commits are decided here
    // so that the output registers and the ack path see the same decision.
    always_comb begin
        w_state_nx = r_state;
        w_err      = 1'b0;
        w_err_code = c_ERR_CHKSUM;
        w_ok       = 1'b0;
        // A byte arriving on the limit cycle still counts as in time.
        w_timeout  = (r_state != c_ST_IDLE) && !rx_dv && (r_tcnt == c_TLIM);

        if (w_timeout) begin
            w_state_nx = c_ST_IDLE;
            w_err      = 1'b1;
            w_err_code = c_ERR_TIMEOUT;
        end else if (rx_dv) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (rx_byte == SYNC_BYTE) w_state_nx = c_ST_CMD;
                end
                c_ST_CMD: w_state_nx = c_ST_LEN;
                c_ST_LEN: begin
                    if (!f_len_ok(r_cmd, rx_byte)) begin
                        w_state_nx = c_ST_IDLE;
                        w_err      = 1'b1;
                        w_err_code = c_ERR_BADCMD;
                    end else if (rx_byte == 8'd0) begin
                        w_state_nx = c_ST_CHK;
                    end else begin
                        w_state_nx = c_ST_PAYLOAD;
                    end
                end
                c_ST_PAYLOAD: begin
                    if (r_rem == 5'd1) w_state_nx = c_ST_CHK;
                end
                c_ST_CHK: begin
                    w_state_nx = c_ST_IDLE;
                    if (rx_byte != r_chk) begin
                        w_err      = 1'b1;
                        w_err_code = c_ERR_CHKSUM;
                    end else if ((r_cmd == c_CMD_SET_DELAY) && (r_stage[7:0] > 8'(MAX_DELAY))) begin
                        w_err      = 1'b1;
                        w_err_code = c_ERR_BADCMD;
                    end else if ((r_cmd == c_CMD_START) && busy_i) begin
                        w_err      = 1'b1;
                        w_err_code = c_ERR_BUSY;
                    end else begin
                        w_ok = 1'b1;
                    end
                end
                default: w_state_nx = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cmd     <= 8'd0;
            r_chk     <= 8'd0;
            r_rem     <= 5'd0;
            r_stage   <= 128'd0;
            r_tcnt    <= '0;
            key_o     <= 128'd0;
            pt_o      <= 128'd0;
            delay_o   <= 5'd0;
            err_code  <= c_ERR_CHKSUM;
            key_vld   <= 1'b0;
            pt_vld    <= 1'b0;
            delay_vld <= 1'b0;
            start_o   <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            key_vld   <= 1'b0;
            pt_vld    <= 1'b0;
            delay_vld <= 1'b0;
            start_o   <= 1'b0;
            err_o     <= 1'b0;

            if (rx_dv || (w_state_nx == c_ST_IDLE)) r_tcnt <= '0;
            else                                    r_tcnt <= r_tcnt + 1'b1;

            if (w_timeout) r_stage <= 128'd0;

            if (rx_dv) begin
                case (r_state)
                    c_ST_CMD: begin
                        r_cmd <= rx_byte;
                        r_chk <= rx_byte;
                    end
                    c_ST_LEN: begin
                        r_chk <= r_chk ^ rx_byte;
                        r_rem <= rx_byte[4:0];
                    end
                    c_ST_PAYLOAD: begin
                        // First payload byte ends up in [127:120] after 16 shifts.
                        r_stage <= {r_stage[119:0], rx_byte};
                        r_chk   <= r_chk ^ rx_byte;
                        r_rem   <= r_rem - 5'd1;
                    end
                    default: ;
                endcase
            end

            if (w_err) begin
                err_o    <= 1'b1;
                err_code <= w_err_code;
            end

            if (w_ok) begin
                case (r_cmd)
                    c_CMD_SET_KEY: begin
                        key_o   <= r_stage;
                        key_vld <= 1'b1;
                    end
                    c_CMD_SET_PT: begin
                        pt_o   <= r_stage;
                        pt_vld <= 1'b1;
                    end
                    c_CMD_SET_DELAY: begin
                        delay_o   <= r_stage[4:0];
                        delay_vld <= 1'b1;
                    end
                    default: start_o <= 1'b1;
                endcase
            end
        end
    end

`ifdef CMD_ACK_EN
    // One-deep ack slot; a newer verdict overwrites an unconsumed one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_valid <= 1'b0;
            ack_byte  <= 8'd0;
        end else if (w_err) begin
            ack_valid <= 1'b1;
            ack_byte  <= 8'hE0 | {6'd0, w_err_code};
        end else if (w_ok) begin
            ack_valid <= 1'b1;
            ack_byte  <= r_cmd | 8'h80;
        end else if (ack_ready) begin
            ack_valid <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire
